// File: rtl/tt_um_richard28277.sv
// rtl/tt_um_richard28277.sv - 4-bit registered ALU in the TinyTapeout wrapper
// Optional multiplier/divider (opcodes 2, 3) built only when MULDIV_EN is defined.
module tt_um_richard28277 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] opcode;
  logic [1:0] sh;
  logic [4:0] sum5;
  logic [4:0] diff5;
  logic [7:0] shl_t;
  logic [7:0] shr_t;
  logic [7:0] rol_t;
  logic       unused_uio;

  logic [7:0] r_d, r_q;
  logic       c_d, c_q;
  logic       v_d, v_q;
  logic       z_d, z_q;
  logic       e_d, e_q;

  assign a          = ui_in[7:4];
  assign b          = ui_in[3:0];
  assign opcode     = uio_in[3:0];
  assign sh         = b[1:0];
  assign unused_uio = &{1'b0, uio_in[7:4]};

  assign sum5  = {1'b0, a} + {1'b0, b};
  assign diff5 = {1'b0, a} - {1'b0, b};
  // Shifts run in 8-bit windows so the bit just past the nibble is the last bit shifted out.
  assign shl_t = {4'b0000, a} << sh;
  assign shr_t = {a, 4'b0000} >> sh;
  assign rol_t = {a, a} << sh;

  always_comb begin
    r_d = 8'h00;
    c_d = 1'b0;
    v_d = 1'b0;
    e_d = 1'b0;
    case (opcode)
      4'd0: begin
        r_d = {3'b000, sum5};
        c_d = sum5[4];
        v_d = (a[3] == b[3]) && (sum5[3] != a[3]);
      end
      4'd1: begin
        r_d = {4'h0, diff5[3:0]};
        c_d = (a < b);
        v_d = (a[3] != b[3]) && (diff5[3] != a[3]);
      end
`ifdef MULDIV_EN
      4'd2: r_d = {4'h0, a} * {4'h0, b};
      4'd3: begin
        if (b == 4'h0) begin
          e_d = 1'b1;
        end else begin
          r_d = {a % b, a / b};
        end
      end
`endif
      4'd4:  r_d = {4'h0, a & b};
      4'd5:  r_d = {4'h0, a | b};
      4'd6:  r_d = {4'h0, a ^ b};
      4'd7:  r_d = {4'h0, ~a};
      4'd8: begin
        r_d = {4'h0, shl_t[3:0]};
        c_d = (sh != 2'd0) && shl_t[4];
      end
      4'd9: begin
        r_d = {4'h0, shr_t[7:4]};
        c_d = (sh != 2'd0) && shr_t[3];
      end
      4'd10: r_d = {4'h0, rol_t[7:4]};
      4'd11: r_d = {5'b00000, (a > b), (a == b), (a < b)};
      default: e_d = 1'b1;
    endcase
    z_d = (r_d == 8'h00);
  end

  // rst_n is active-high here despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_q <= 8'h00;
      c_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
      e_q <= 1'b0;
    end else if (ena) begin
      r_q <= r_d;
      c_q <= c_d;
      v_q <= v_d;
      z_q <= z_d;
      e_q <= e_d;
    end
  end

  assign uo_out  = r_q;
  assign uio_out = {e_q, z_q, v_q, c_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_richard28277.sv
// tb/tb_tt_um_richard28277.sv - scoreboard bench for the 4-bit registered ALU
module tb_tt_um_richard28277;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    logic [7:0] r;
    logic [7:0] f;
    int         due;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  tt_um_richard28277 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] fl(input logic e, input logic z, input logic v, input logic c);
    return {e, z, v, c, 4'b0000};
  endfunction

  // Monitor: pops every expectation whose capture edge has passed.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk({e.name, " R"}, uo_out, e.r);
      chk({e.name, " flags"}, uio_out, e.f);
      chk({e.name, " oe"}, uio_oe, 8'hF0);
    end
  end

  task automatic issue(input string nm, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic en,
                       input logic [7:0] er, input logic [7:0] ef);
    exp_t e;
    @(posedge clk);
    #2;
    ui_in  = {a, b};
    uio_in = {4'hA, op};
    ena    = en;
    e.r    = er;
    e.f    = ef;
    e.due  = cyc + 1;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n = n + 1;
    end
    @(negedge clk);
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #1;
    chk("reset R", uo_out, 8'h00);
    chk("reset flags", uio_out, 8'h00);
    chk("reset oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b0;

    issue("add 9+7",   4'd9,  4'd7,  4'd0, 1'b1, 8'h10, fl(0, 0, 0, 1));
    issue("add 15+15", 4'd15, 4'd15, 4'd0, 1'b1, 8'h1E, fl(0, 0, 0, 1));
    issue("add 4+4",   4'd4,  4'd4,  4'd0, 1'b1, 8'h08, fl(0, 0, 1, 0));
    issue("sub 3-5",   4'd3,  4'd5,  4'd1, 1'b1, 8'h0E, fl(0, 0, 0, 1));
    issue("sub 8-1",   4'd8,  4'd1,  4'd1, 1'b1, 8'h07, fl(0, 0, 1, 0));
    issue("sub 5-5",   4'd5,  4'd5,  4'd1, 1'b1, 8'h00, fl(0, 1, 0, 0));
`ifdef MULDIV_EN
    issue("mul 15*15", 4'd15, 4'd15, 4'd2, 1'b1, 8'hE1, fl(0, 0, 0, 0));
    issue("div 13/4",  4'd13, 4'd4,  4'd3, 1'b1, 8'h13, fl(0, 0, 0, 0));
`else
    issue("mul off",   4'd15, 4'd15, 4'd2, 1'b1, 8'h00, fl(1, 1, 0, 0));
    issue("div off",   4'd13, 4'd4,  4'd3, 1'b1, 8'h00, fl(1, 1, 0, 0));
`endif
    issue("div by 0",  4'd7,  4'd0,  4'd3, 1'b1, 8'h00, fl(1, 1, 0, 0));
    issue("and",       4'hB,  4'h6,  4'd4, 1'b1, 8'h02, fl(0, 0, 0, 0));
    issue("or",        4'hB,  4'h6,  4'd5, 1'b1, 8'h0F, fl(0, 0, 0, 0));
    issue("xor",       4'hB,  4'h6,  4'd6, 1'b1, 8'h0D, fl(0, 0, 0, 0));
    issue("not",       4'hB,  4'h6,  4'd7, 1'b1, 8'h04, fl(0, 0, 0, 0));
    issue("shl 2",     4'hB,  4'd2,  4'd8, 1'b1, 8'h0C, fl(0, 0, 0, 0));
    issue("shr 2",     4'hB,  4'd2,  4'd9, 1'b1, 8'h02, fl(0, 0, 0, 1));
    issue("rol 2",     4'hB,  4'd2,  4'd10, 1'b1, 8'h0E, fl(0, 0, 0, 0));
    issue("shl 0",     4'hB,  4'd4,  4'd8, 1'b1, 8'h0B, fl(0, 0, 0, 0));
    issue("shr 1",     4'hB,  4'd1,  4'd9, 1'b1, 8'h05, fl(0, 0, 0, 1));
    issue("shl 3",     4'h3,  4'd3,  4'd8, 1'b1, 8'h08, fl(0, 0, 0, 1));
    issue("cmp 5,9",   4'd5,  4'd9,  4'd11, 1'b1, 8'h01, fl(0, 0, 0, 0));
    issue("cmp 7,7",   4'd7,  4'd7,  4'd11, 1'b1, 8'h02, fl(0, 0, 0, 0));
    issue("cmp 9,5",   4'd9,  4'd5,  4'd11, 1'b1, 8'h04, fl(0, 0, 0, 0));
    issue("op 13",     4'd9,  4'd5,  4'd13, 1'b1, 8'h00, fl(1, 1, 0, 0));
    issue("op 15",     4'd9,  4'd5,  4'd15, 1'b1, 8'h00, fl(1, 1, 0, 0));
    issue("add 6+6",   4'd6,  4'd6,  4'd0, 1'b1, 8'h0C, fl(0, 0, 1, 0));
    issue("hold 1",    4'd1,  4'd1,  4'd4, 1'b0, 8'h0C, fl(0, 0, 1, 0));
    issue("hold 2",    4'd0,  4'd0,  4'd13, 1'b0, 8'h0C, fl(0, 0, 1, 0));
    issue("hold 3",    4'd3,  4'd5,  4'd1, 1'b0, 8'h0C, fl(0, 0, 1, 0));
    issue("resume",    4'd3,  4'd5,  4'd1, 1'b1, 8'h0E, fl(0, 0, 0, 1));
    issue("cmp 9,5 b", 4'd9,  4'd5,  4'd11, 1'b1, 8'h04, fl(0, 0, 0, 0));
    drain();

    // Asynchronous reset with an operation already on the inputs.
    @(posedge clk);
    #2;
    ui_in  = {4'd1, 4'd2};
    uio_in = 8'h00;
    ena    = 1'b1;
    #1;
    rst_n = 1'b1;
    #1;
    chk("async rst R", uo_out, 8'h00);
    chk("async rst flags", uio_out, 8'h00);
    chk("async rst oe", uio_oe, 8'hF0);
    @(posedge clk);
    #1;
    chk("rst held R", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;

    issue("post rst add", 4'd1, 4'd2, 4'd0, 1'b1, 8'h03, fl(0, 0, 0, 0));
    issue("post rst xor", 4'hF, 4'hF, 4'd6, 1'b1, 8'h00, fl(0, 1, 0, 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
